pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters: none; register index width fixed at 5, counter width fixed at 16.
REQ-002 Ports:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- CLEAR  in  1  pipeline freeze request.
- inst_id  in  32  instruction currently in ID.
- rd_ex  in  5  destination register of the EX instruction.
- reg_write_ex  in  1  write-enable of the EX instruction.
- mem_read_ex  in  1  EX instruction is a load.
- rd_mem  in  5  destination register of the MEM instruction.
- reg_write_mem  in  1  write-enable of the MEM instruction.
- rd_wb  in  5  destination register of the WB instruction.
- reg_write_wb  in  1  write-enable of the WB instruction.
- branch_taken_mem  in  1  taken branch resolved in MEM (PCSrc).
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  bubble insert per register.
- stall_cnt  out  16  saturating count of stall cycles.
- flush_cnt  out  16  saturating count of taken-branch flushes.

Function
REQ-003 rs1 = inst_id[19:15], used unless opcode is 0110111, 0010111 or 1101111; rs2 = inst_id[24:20], used only for opcodes 0110011, 0100011 and 1100011.
REQ-004 Match = source used, source equals producer rd, producer write-enable high, and rd nonzero; x0 never matches.
REQ-005 FSM states: RUN, STALL; 2-bit down-counter scnt.
REQ-006 RUN with no hazard and no branch: pc_write=1, if_id_write=1, all flushes 0.
REQ-007 RUN with hazard of stall length N≥1: pc_write=0, if_id_write=0, id_ex_flush=1 in the same cycle; if N>1, go to STALL with scnt=N-1.
REQ-008 STALL: same outputs as REQ-007; scnt decrements each cycle; return to RUN on the cycle scnt reaches 1 to 0 transition, i.e. after exactly N total stall cycles.
REQ-009 Hazard is evaluated only in RUN; STALL length is fixed at entry and not re-evaluated.
REQ-010 branch_taken_mem=1, any state: pc_write=1, if_id_write=1, if_id_flush=id_ex_flush=ex_mem_flush=1; next state RUN with scnt=0, aborting any stall; overrides hazard and REQ-007/008.
REQ-011 CLEAR=1 and no branch: pc_write=0, if_id_write=0, all flushes 0; state and scnt hold; counters do not increment.
REQ-012 Precedence: RESET > branch_taken_mem > CLEAR > stall > run.
REQ-013 stall_cnt increments on each cycle with id_ex_flush=1 due to a stall (not a branch); flush_cnt increments on each branch cycle; both saturate at 16'hFFFF with no wrap.
REQ-014 All outputs except the counters are combinational from state, scnt and inputs; the counters are registered.

Reset
REQ-015 RESET=1 at a CLK edge: state=RUN, scnt=0, stall_cnt=0, flush_cnt=0.
REQ-016 While RESET=1: pc_write=0, if_id_write=0, all three flushes=1, regardless of other inputs.
REQ-017 Reset asserted mid-STALL aborts the stall; first post-reset cycle behaves per REQ-006/007.

Configuration
REQ-018 Macro HAZARD_FORWARDING_EN.
- Defined: only load-use stalls; match against rd_ex with mem_read_ex=1 gives N=1; MEM/WB matches are ignored.
- Undefined: match vs EX gives N=3, else vs MEM gives N=2, else vs WB gives N=1; nearest stage wins; mem_read_ex is ignored.

Verification
REQ-019 Forwarding undefined, add x5 in EX (reg_write_ex=1, rd_ex=5), ID add x6,x5,x1 -> pc_write=0 for exactly 3 cycles, stall_cnt=3, then RUN.
REQ-020 Forwarding defined, load x7 in EX (mem_read_ex=1), ID sw x7 -> exactly 1 stall cycle, id_ex_flush=1 that cycle, stall_cnt=1; with mem_read_ex=0 -> 0 stalls.
REQ-021 rd_ex=0 with reg_write_ex=1, ID uses x0 -> no stall; LUI in ID with rd_ex matching bits[19:15] -> no stall.
REQ-022 Branch_taken_mem=1 on the 2nd cycle of a 3-cycle stall -> that cycle all flushes=1, pc_write=1; next cycle RUN; flush_cnt=1, stall_cnt=1.
REQ-023 CLEAR=1 for 4 cycles during STALL with scnt=2 -> state/scnt frozen, counters unchanged; stall resumes and completes after CLEAR drops.
REQ-024 Force stall_cnt to 16'hFFFE, apply 3 stall cycles -> stall_cnt=16'hFFFF; RESET mid-stall -> outputs per REQ-016, counters=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - ID-stage hazard controller (stall/flush sequencing, optional HAZARD_FORWARDING_EN)
module pipeline_hazard_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CLEAR,
  input  logic [31:0] inst_id,
  input  logic [4:0]  rd_ex,
  input  logic        reg_write_ex,
  input  logic        mem_read_ex,
  input  logic [4:0]  rd_mem,
  input  logic        reg_write_mem,
  input  logic [4:0]  rd_wb,
  input  logic        reg_write_wb,
  input  logic        branch_taken_mem,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state, state_next;
  logic [1:0]  scnt, scnt_next;
  logic [1:0]  hz_len;
  logic        stall_inc, flush_inc;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2;
  logic        rs1_used, rs2_used;
  logic        match_ex, match_mem, match_wb;

  // Source-register decode: which fields of the ID instruction are real register reads
  always_comb begin
    opcode   = inst_id[6:0];
    rs1      = inst_id[19:15];
    rs2      = inst_id[24:20];
    rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    rs2_used = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  end

  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_id[31:25], inst_id[14:7]};

  // Producer match per stage; writes to x0 never create a dependency
  always_comb begin
    match_ex  = reg_write_ex && (rd_ex != 5'd0) &&
                ((rs1_used && (rs1 == rd_ex)) || (rs2_used && (rs2 == rd_ex)));
    match_mem = reg_write_mem && (rd_mem != 5'd0) &&
                ((rs1_used && (rs1 == rd_mem)) || (rs2_used && (rs2 == rd_mem)));
    match_wb  = reg_write_wb && (rd_wb != 5'd0) &&
                ((rs1_used && (rs1 == rd_wb)) || (rs2_used && (rs2 == rd_wb)));
  end

`ifdef HAZARD_FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = match_mem ^ match_wb;

  // With forwarding only a load feeding the next instruction needs a bubble
  always_comb begin
    hz_len = (match_ex && mem_read_ex) ? 2'd1 : 2'd0;
  end
`else
  logic unused_fwd;
  assign unused_fwd = mem_read_ex;

  // Without forwarding wait until the nearest producer has written back
  always_comb begin
    hz_len = 2'd0;
    if (match_ex)
      hz_len = 2'd3;
    else if (match_mem)
      hz_len = 2'd2;
    else if (match_wb)
      hz_len = 2'd1;
  end
`endif

  // State and stall down-counter register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
      scnt  <= 2'd0;
    end else begin
      state <= state_next;
      scnt  <= scnt_next;
    end
  end

  // Next state and pipeline controls; priority reset > branch > clear > stall > run
  always_comb begin
    state_next   = state;
    scnt_next    = scnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (RESET) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_next   = RUN;
      scnt_next    = 2'd0;
    end else if (branch_taken_mem) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      flush_inc    = 1'b1;
      state_next   = RUN;
      scnt_next    = 2'd0;
    end else if (CLEAR) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
    end else if (state == STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
      stall_inc    = 1'b1;
      scnt_next    = scnt - 2'd1;
      if (scnt == 2'd1)
        state_next = RUN;
    end else if (hz_len != 2'd0) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
      stall_inc    = 1'b1;
      if (hz_len > 2'd1) begin
        state_next = STALL;
        scnt_next  = hz_len - 2'd1;
      end
    end
  end

  // Saturating event counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_inc && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush_inc && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule
